cpu_mem_arbiter: RTL and testbench

Memory arbiter and run sequencer for the 8-bit RISC CPU. It owns the single-port 32x8 program/data memory and shares it between the external program loader (a byte stream, one byte per address from 0x00) and the CPU core. It holds the core in reset and stopped while an image is loaded, releases it with a timed reset pulse, and stops it again on HLT or a new load request.

---
 rtl/cpu_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
// Memory arbiter and run sequencer for the 8-bit RISC CPU. Shares the single
// port program/data memory between the external program loader and the CPU
// core, and sequences the core through reset / run / halt around image loads.
//
// Ports
//   i_clock, i_reset          rising-edge clock, async active-low reset
//   i_load_req                loader requests memory ownership (level)
//   i_load_valid/i_load_data  loader byte stream
//   o_load_ready              loader byte accepted on valid & ready
//   o_load_count              bytes written in current/last load (0..2^AW)
//   i_cpu_req/we/addr/wdata   CPU memory access port
//   i_cpu_halt                CPU decoded HLT
//   o_cpu_gnt                 CPU access accepted on req & gnt
//   o_cpu_rvalid/o_cpu_rdata  read return, one cycle after a granted read
//   o_cpu_run, o_cpu_rst_n    CPU clock-enable and active-low reset
//   o_mem_*/i_mem_rdata       synchronous single-port memory, 1-cycle read
//   o_state                   debug: IDLE=0 LOAD=1 START=2 RUN=3 HALT=4
// ---------------------------------------------------------------------------
module cpu_mem_arbiter #(
   parameter int AW           = 5,
   parameter int DW           = 8,
   parameter int START_CYCLES = 2
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_load_req,
   input  logic          i_load_valid,
   input  logic [DW-1:0] i_load_data,
   output logic          o_load_ready,
   output logic [AW:0]   o_load_count,
   input  logic          i_cpu_req,
   input  logic          i_cpu_we,
   input  logic [AW-1:0] i_cpu_addr,
   input  logic [DW-1:0] i_cpu_wdata,
   input  logic          i_cpu_halt,
   output logic          o_cpu_gnt,
   output logic          o_cpu_rvalid,
   output logic [DW-1:0] o_cpu_rdata,
   output logic          o_cpu_run,
   output logic          o_cpu_rst_n,
   output logic          o_mem_en,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   output logic [2:0]    o_state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   localparam int              SCW       = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [SCW-1:0]  SC_LAST   = SCW'(START_CYCLES - 1);
   localparam logic [AW-1:0]   ADDR_LAST = '1;

   logic [2:0]     r_state;
   logic [AW-1:0]  r_addr;
   logic [AW:0]    r_load_count;
   logic [SCW-1:0] r_start_cnt;
   logic           r_rvalid;

   logic w_accept;
   logic w_cpu_gnt;
   logic w_cpu_acc;

   assign w_accept  = (r_state == S_LOAD) & i_load_valid;
   // Loader and HLT both take priority over any CPU access in the same cycle.
   assign w_cpu_gnt = (r_state == S_RUN) & ~i_load_req & ~i_cpu_halt;
   assign w_cpu_acc = w_cpu_gnt & i_cpu_req;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_load_count <= '0;
         r_start_cnt  <= '0;
         r_rvalid     <= 1'b0;
      end else begin
         // Registered independently of state so a read granted in the last
         // RUN cycle still returns its valid.
         r_rvalid <= w_cpu_acc & ~i_cpu_we;
         case (r_state)
            S_IDLE: begin
               if (i_load_req) begin
                  r_state      <= S_LOAD;
                  r_addr       <= '0;
                  r_load_count <= '0;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_addr       <= r_addr + AW'(1);
                  r_load_count <= r_load_count + (AW+1)'(1);
               end
               // Top address ends the load (no wrap); a byte accepted as
               // load_req falls has already been written above.
               if ((w_accept && (r_addr == ADDR_LAST)) || !i_load_req) begin
                  r_state     <= S_START;
                  r_start_cnt <= '0;
               end
            end
            S_START: begin
               if (r_start_cnt == SC_LAST) begin
                  r_state <= S_RUN;
               end else begin
                  r_start_cnt <= r_start_cnt + SCW'(1);
               end
            end
            S_RUN: begin
               if (i_load_req) begin
                  r_state      <= S_LOAD;
                  r_addr       <= '0;
                  r_load_count <= '0;
               end else if (i_cpu_halt) begin
                  r_state <= S_HALT;
               end
            end
            S_HALT: begin
               if (i_load_req) begin
                  r_state      <= S_LOAD;
                  r_addr       <= '0;
                  r_load_count <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (w_accept) begin
         o_mem_en    = 1'b1;
         o_mem_we    = 1'b1;
         o_mem_addr  = r_addr;
         o_mem_wdata = i_load_data;
      end else if (w_cpu_acc) begin
         o_mem_en    = 1'b1;
         o_mem_we    = i_cpu_we;
         o_mem_addr  = i_cpu_addr;
         o_mem_wdata = i_cpu_wdata;
      end
   end

   assign o_load_ready = (r_state == S_LOAD);
   assign o_load_count = r_load_count;
   assign o_cpu_gnt    = w_cpu_gnt;
   assign o_cpu_rvalid = r_rvalid;
   assign o_cpu_rdata  = i_mem_rdata;
   assign o_cpu_run    = (r_state == S_RUN);
   // CPU reset is released in RUN and kept released in HALT so its state
   // stays observable.
   assign o_cpu_rst_n  = (r_state == S_RUN) | (r_state == S_HALT);
   assign o_state      = r_state;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_req, load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic [5:0] load_count;
   logic       cpu_req, cpu_we, cpu_halt;
   logic [4:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_gnt, cpu_rvalid, cpu_run, cpu_rst_n;
   logic [7:0] cpu_rdata;
   logic       mem_en, mem_we;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic [2:0] state;

   int tests = 0;
   int fails = 0;

   logic [7:0] mem [0:31];

   always #5 clk = ~clk;

   // Synchronous single-port memory, 1-cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   cpu_mem_arbiter #(.AW(5), .DW(8), .START_CYCLES(2)) dut (
      .i_clock(clk), .i_reset(rst_n),
      .i_load_req(load_req), .i_load_valid(load_valid), .i_load_data(load_data),
      .o_load_ready(load_ready), .o_load_count(load_count),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
      .i_cpu_wdata(cpu_wdata), .i_cpu_halt(cpu_halt),
      .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
      .o_cpu_run(cpu_run), .o_cpu_rst_n(cpu_rst_n),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_state(state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] img(input int i);
      if (i % 2 == 1) return 8'h00;
      if (i == 30)    return 8'hE3;
      return 8'(8'hFE - i);
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_state"},  32'(state),      32'd0);
      chk({tag, "_count"},  32'(load_count), 32'd0);
      chk({tag, "_ready"},  32'(load_ready), 32'd0);
      chk({tag, "_run"},    32'(cpu_run),    32'd0);
      chk({tag, "_rst_n"},  32'(cpu_rst_n),  32'd0);
      chk({tag, "_gnt"},    32'(cpu_gnt),    32'd0);
      chk({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd0);
      chk({tag, "_mem_en"}, 32'(mem_en),     32'd0);
   endtask

   initial begin
      rst_n = 1'b0; load_req = 0; load_valid = 0; load_data = 0;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_halt = 0;
      #3;
      chk_reset_outputs("por");
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("idle_hold", 32'(state), 32'd0);

      // ---- Full load: 32 continuous bytes ----
      load_req = 1;
      #1;
      chk("idle_no_ready", 32'(load_ready), 32'd0);
      tick();
      chk("load_entered", 32'(state), 32'd1);
      chk("load_ready",   32'(load_ready), 32'd1);
      chk("load_cnt0",    32'(load_count), 32'd0);
      for (int i = 0; i < 32; i++) begin
         load_valid = 1; load_data = img(i);
         #1;
         chk($sformatf("full_wr%0d_addr", i), 32'(mem_addr), 32'(i));
         chk($sformatf("full_wr%0d_en", i), 32'({mem_en, mem_we}), 32'b11);
         tick();
         $display("[TB] load byte %0d addr %0d data %02h", i, i, img(i));
      end
      load_valid = 0; load_req = 0;
      chk("full_start",     32'(state),      32'd2);
      chk("full_count32",   32'(load_count), 32'd32);
      chk("start_rst_n",    32'(cpu_rst_n),  32'd0);
      chk("start_run",      32'(cpu_run),    32'd0);
      tick();
      chk("start_cycle2",   32'(state),      32'd2);
      chk("start2_rst_n",   32'(cpu_rst_n),  32'd0);
      tick();
      chk("run_entered",    32'(state),      32'd3);
      chk("run_cpu_run",    32'(cpu_run),    32'd1);
      chk("run_rst_n",      32'(cpu_rst_n),  32'd1);
      chk("mem00", 32'(mem[0]),  32'h00FE);
      chk("mem1E", 32'(mem[30]), 32'h00E3);
      chk("mem1F", 32'(mem[31]), 32'h0000);

      // ---- CPU write then read of 0x1C ----
      cpu_req = 1; cpu_we = 1; cpu_addr = 5'h1C; cpu_wdata = 8'hAA;
      #1;
      chk("wr_gnt",    32'(cpu_gnt),   32'd1);
      chk("wr_mem",    32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 5'h1C, 8'hAA}));
      tick();
      $display("[TB] cpu write addr 1c data aa");
      cpu_we = 0;
      #1;
      chk("rd_gnt",    32'(cpu_gnt),   32'd1);
      chk("rd_mem_we", 32'({mem_en, mem_we}), 32'b10);
      chk("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
      tick();
      cpu_req = 0;
      chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
      chk("rd_rdata",  32'(cpu_rdata),  32'h00AA);
      $display("[TB] cpu read addr 1c data %02h", cpu_rdata);
      tick();
      chk("rd_rvalid_drop", 32'(cpu_rvalid), 32'd0);

      // ---- Preemption: load_req and a CPU read in the same cycle ----
      load_req = 1; cpu_req = 1; cpu_addr = 5'h1A;
      #1;
      chk("pre_no_gnt", 32'(cpu_gnt), 32'd0);
      chk("pre_mem_en", 32'(mem_en),  32'd0);
      tick();
      cpu_req = 0;
      chk("pre_load",      32'(state),      32'd1);
      chk("pre_no_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("pre_cnt0",      32'(load_count), 32'd0);
      $display("[TB] preemption: state %0d", state);

      // ---- Partial load with gaps; last byte arrives as load_req falls ----
      for (int i = 0; i < 7; i++) begin
         load_valid = (i % 2 == 0);
         load_data  = 8'(8'h11 * (i / 2 + 1));
         if (i == 6) load_req = 0;
         #1;
         chk($sformatf("part_en%0d", i), 32'(mem_en), 32'(i % 2 == 0));
         tick();
      end
      load_valid = 0;
      chk("part_start", 32'(state),      32'd2);
      chk("part_count", 32'(load_count), 32'd4);
      $display("[TB] partial load count %0d", load_count);
      for (int i = 0; i < 4; i++)
         chk($sformatf("part_mem%0d", i), 32'(mem[5'(i)]), 32'(8'h11 * (i + 1)));
      chk("part_mem04", 32'(mem[4]),  32'h00FA);
      chk("part_mem05", 32'(mem[5]),  32'h0000);
      chk("part_mem1C", 32'(mem[28]), 32'h00AA);
      tick(); tick();
      chk("part_run", 32'(state), 32'd3);

      // ---- Halt ----
      cpu_halt = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 5'h01;
      #1;
      chk("halt_no_gnt", 32'(cpu_gnt), 32'd0);
      tick();
      cpu_halt = 0;
      chk("halt_state", 32'(state),     32'd4);
      chk("halt_run",   32'(cpu_run),   32'd0);
      chk("halt_rst_n", 32'(cpu_rst_n), 32'd1);
      chk("halt_gnt",   32'(cpu_gnt),   32'd0);
      chk("halt_mem_en", 32'(mem_en),   32'd0);
      tick();
      chk("halt_held",  32'(state),     32'd4);
      $display("[TB] halt: state %0d", state);
      cpu_req = 0; load_req = 1;
      tick();
      chk("halt_to_load", 32'(state), 32'd1);

      // ---- Reset mid-load after 10 bytes ----
      for (int i = 0; i < 10; i++) begin
         load_valid = 1; load_data = 8'(8'hA0 + i);
         tick();
      end
      chk("rst_pre_count", 32'(load_count), 32'd10);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midload");
      $display("[TB] async reset mid-load: state %0d count %0d", state, load_count);
      for (int i = 0; i < 10; i++)
         chk($sformatf("rst_mem%0d", i), 32'(mem[5'(i)]), 32'(8'hA0 + i));
      chk("rst_mem0A", 32'(mem[10]), 32'h00F4);
      load_valid = 0; load_req = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
